// File: rtl/vend_ctrl_if.sv
// Coin/select/buy inputs and vend/change/status outputs of the
// vending transaction sequencer, bundled for the controller port.
interface vend_ctrl_if;
  logic       coin_half;
  logic       coin_one;
  logic       coin_five;
  logic       coin_ten;
  logic [1:0] sel;
  logic       buy;
  logic       cancel;
  logic [5:0] coin_sum;
  logic       coin_reject;
  logic       vend_pulse;
  logic [1:0] vend_item;
  logic       change_one;
  logic       change_half;
  logic       insufficient;
  logic       busy;

  modport master (
    output coin_half, coin_one, coin_five, coin_ten,
    output sel, buy, cancel,
    input  coin_sum, coin_reject, vend_pulse, vend_item,
    input  change_one, change_half, insufficient, busy
  );

  modport slave (
    input  coin_half, coin_one, coin_five, coin_ten,
    input  sel, buy, cancel,
    output coin_sum, coin_reject, vend_pulse, vend_item,
    output change_one, change_half, insufficient, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// Vending transaction sequencer: credit, buy/cancel, vend, timed change.
// Optional VEND_TIMEOUT_REFUND_EN: auto-refund after TIMEOUT_CYC idle cycles.
module vend_ctrl #(
  parameter int PRICE0      = 5,
  parameter int PRICE1      = 10,
  parameter int PRICE2      = 15,
  parameter int PRICE3      = 20,
  parameter int CHANGE_GAP  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic        clk,
  input logic        rst,
  vend_ctrl_if.slave bus
);
  localparam int GW = $clog2(CHANGE_GAP + 1);

  typedef enum logic [1:0] {
    IDLE, COLLECT, VEND, CHANGE
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    credit_q, credit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          rej_q, rej_d;
  logic          vend_q, vend_d;
  logic [1:0]    item_q, item_d;
  logic          one_q, one_d;
  logic          half_q, half_d;
  logic          insuf_q, insuf_d;
  logic          busy_q, busy_d;

  logic       any_coin;
  logic       multi;
  logic [5:0] win_val;
  logic [5:0] price;
  logic [6:0] sum;
  logic       cancel_eff;

`ifdef VEND_TIMEOUT_REFUND_EN
  logic [15:0] to_q, to_d;
  logic        to_fire;

  assign to_fire = (state_q == COLLECT) &&
                   (to_q == 16'(TIMEOUT_CYC - 1));
  assign cancel_eff = bus.cancel | to_fire;

  // Counts only while credit sits untouched in COLLECT.
  always_comb begin
    to_d = '0;
    if (state_q == COLLECT && state_d == COLLECT &&
        !bus.buy && !bus.cancel && credit_d == credit_q)
      to_d = to_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`else
  assign cancel_eff = bus.cancel;
`endif

  always_comb begin
    any_coin = bus.coin_ten | bus.coin_five |
               bus.coin_one | bus.coin_half;
    multi = (3'(bus.coin_ten) + 3'(bus.coin_five) +
             3'(bus.coin_one) + 3'(bus.coin_half)) > 3'd1;
    if (bus.coin_ten)       win_val = 6'd20;
    else if (bus.coin_five) win_val = 6'd10;
    else if (bus.coin_one)  win_val = 6'd2;
    else if (bus.coin_half) win_val = 6'd1;
    else                    win_val = 6'd0;
    sum = {1'b0, credit_q} + {1'b0, win_val};
    unique case (bus.sel)
      2'd0: price = 6'(PRICE0);
      2'd1: price = 6'(PRICE1);
      2'd2: price = 6'(PRICE2);
      2'd3: price = 6'(PRICE3);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    gap_d    = gap_q;
    rej_d    = 1'b0;
    vend_d   = 1'b0;
    item_d   = 2'd0;
    one_d    = 1'b0;
    half_d   = 1'b0;
    insuf_d  = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (cancel_eff || bus.buy) begin
          rej_d = any_coin;
          if (cancel_eff) begin
            if (state_q == COLLECT) begin
              state_d = CHANGE;
              gap_d   = '0;
            end
          end else if (state_q == COLLECT &&
                       credit_q >= price) begin
            state_d  = VEND;
            vend_d   = 1'b1;
            item_d   = bus.sel;
            credit_d = credit_q - price;
          end else begin
            insuf_d = 1'b1;
          end
        end else if (any_coin) begin
          if (sum > 7'd63) begin
            rej_d = 1'b1;
          end else begin
            credit_d = sum[5:0];
            state_d  = COLLECT;
            rej_d    = multi;
          end
        end
      end
      VEND: begin
        rej_d   = any_coin;
        gap_d   = '0;
        state_d = (credit_q != 6'd0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_d = any_coin;
        if (gap_q == '0) begin
          if (credit_q >= 6'd2) begin
            one_d    = 1'b1;
            credit_d = credit_q - 6'd2;
            gap_d    = GW'(CHANGE_GAP);
          end else if (credit_q == 6'd1) begin
            half_d   = 1'b1;
            credit_d = 6'd0;
            gap_d    = GW'(CHANGE_GAP);
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
    endcase
    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      gap_q    <= '0;
      rej_q    <= 1'b0;
      vend_q   <= 1'b0;
      item_q   <= 2'd0;
      one_q    <= 1'b0;
      half_q   <= 1'b0;
      insuf_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      gap_q    <= gap_d;
      rej_q    <= rej_d;
      vend_q   <= vend_d;
      item_q   <= item_d;
      one_q    <= one_d;
      half_q   <= half_d;
      insuf_q  <= insuf_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.coin_sum     = credit_q;
  assign bus.coin_reject  = rej_q;
  assign bus.vend_pulse   = vend_q;
  assign bus.vend_item    = item_q;
  assign bus.change_one   = one_q;
  assign bus.change_half  = half_q;
  assign bus.insufficient = insuf_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl.
// Timeout scenario runs only when VEND_TIMEOUT_REFUND_EN is defined.
module tb_vend_ctrl;
  localparam int GAP = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vend_ctrl_if bus ();

  vend_ctrl #(
    .CHANGE_GAP (GAP),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.coin_half = 1'b0;
    bus.coin_one  = 1'b0;
    bus.coin_five = 1'b0;
    bus.coin_ten  = 1'b0;
    bus.sel       = 2'd0;
    bus.buy       = 1'b0;
    bus.cancel    = 1'b0;
  endtask

  // Observe a payout until busy drops; returns counts and spacing status.
  task automatic payout(output int ones, output int halves,
                        output int first_sum, output bit gap_bad,
                        output bit tmo);
    int last;
    ones = 0; halves = 0; first_sum = -1;
    gap_bad = 1'b0; tmo = 1'b1; last = -1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.busy) begin
        tmo = 1'b0;
        break;
      end
      cyc();
      if (bus.change_one || bus.change_half) begin
        if (last >= 0 && (i - last) != GAP + 1) gap_bad = 1'b1;
        if (last < 0) first_sum = int'(bus.coin_sum);
        last = i;
        if (bus.change_one) ones++;
        if (bus.change_half) halves++;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.coin_sum, bus.coin_reject, bus.vend_pulse,
         bus.vend_item, bus.change_one, bus.change_half,
         bus.insufficient, bus.busy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outs got %h want 0", {bus.coin_sum,
               bus.coin_reject, bus.vend_pulse, bus.vend_item,
               bus.change_one, bus.change_half, bus.insufficient,
               bus.busy});
    end
  endtask

  task automatic test_buy_change();
    int o, h, fs;
    bit gb, tm;
    bus.coin_five = 1'b1; cyc(); clr();
    checks++;
    if (bus.coin_sum !== 6'd10) begin
      errors++;
      $display("FAIL five_sum got %0d want 10", bus.coin_sum);
    end
    bus.coin_half = 1'b1; cyc(); clr();
    checks++;
    if (bus.coin_sum !== 6'd11) begin
      errors++;
      $display("FAIL half_sum got %0d want 11", bus.coin_sum);
    end
    bus.buy = 1'b1; bus.sel = 2'd0; cyc(); clr();
    checks++;
    if ({bus.vend_pulse, bus.vend_item, bus.coin_sum, bus.busy}
        !== {1'b1, 2'd0, 6'd6, 1'b1}) begin
      errors++;
      $display("FAIL vend got p%0d i%0d s%0d b%0d want p1 i0 s6 b1",
               bus.vend_pulse, bus.vend_item, bus.coin_sum, bus.busy);
    end
    payout(o, h, fs, gb, tm);
    checks++;
    if (tm || o != 3 || h != 0 || gb || fs != 4 ||
        bus.coin_sum !== 6'd0) begin
      errors++;
      $display("FAIL vend_change got o%0d h%0d fs%0d gap%0d t%0d s%0d want o3 h0 fs4 gap0 t0 s0",
               o, h, fs, gb, tm, bus.coin_sum);
    end
  endtask

  task automatic test_insufficient();
    int o, h, fs;
    bit gb, tm;
    bus.coin_one = 1'b1; cyc(); clr();
    bus.buy = 1'b1; bus.sel = 2'd3; cyc(); clr();
    checks++;
    if ({bus.insufficient, bus.vend_pulse, bus.coin_sum}
        !== {1'b1, 1'b0, 6'd2}) begin
      errors++;
      $display("FAIL insuf got i%0d v%0d s%0d want i1 v0 s2",
               bus.insufficient, bus.vend_pulse, bus.coin_sum);
    end
    bus.buy = 1'b1; bus.sel = 2'd3; bus.coin_half = 1'b1;
    cyc(); clr();
    checks++;
    if ({bus.insufficient, bus.coin_reject, bus.coin_sum}
        !== {1'b1, 1'b1, 6'd2}) begin
      errors++;
      $display("FAIL buy_coin got i%0d r%0d s%0d want i1 r1 s2",
               bus.insufficient, bus.coin_reject, bus.coin_sum);
    end
    bus.cancel = 1'b1; cyc(); clr();
    bus.coin_ten = 1'b1; cyc(); clr();
    checks++;
    if ({bus.change_one, bus.coin_reject, bus.coin_sum}
        !== {1'b1, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL change_coin got c%0d r%0d s%0d want c1 r1 s0",
               bus.change_one, bus.coin_reject, bus.coin_sum);
    end
    payout(o, h, fs, gb, tm);
    checks++;
    if (tm || o != 0 || h != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_end got o%0d h%0d t%0d b%0d want o0 h0 t0 b0",
               o, h, tm, bus.busy);
    end
  endtask

  task automatic test_overflow();
    int o, h, fs;
    bit gb, tm;
    for (int i = 0; i < 3; i++) begin
      bus.coin_ten = 1'b1; cyc(); clr();
    end
    bus.coin_five = 1'b1; cyc(); clr();
    checks++;
    if ({bus.coin_reject, bus.coin_sum} !== {1'b1, 6'd60}) begin
      errors++;
      $display("FAIL ovf_five got r%0d s%0d want r1 s60",
               bus.coin_reject, bus.coin_sum);
    end
    bus.coin_one = 1'b1; cyc(); clr();
    checks++;
    if ({bus.coin_reject, bus.coin_sum} !== {1'b0, 6'd62}) begin
      errors++;
      $display("FAIL ovf_one got r%0d s%0d want r0 s62",
               bus.coin_reject, bus.coin_sum);
    end
    bus.coin_half = 1'b1; cyc(); clr();
    checks++;
    if (bus.coin_sum !== 6'd63) begin
      errors++;
      $display("FAIL ovf_half got %0d want 63", bus.coin_sum);
    end
    bus.coin_half = 1'b1; cyc(); clr();
    checks++;
    if ({bus.coin_reject, bus.coin_sum} !== {1'b1, 6'd63}) begin
      errors++;
      $display("FAIL ovf_full got r%0d s%0d want r1 s63",
               bus.coin_reject, bus.coin_sum);
    end
    bus.cancel = 1'b1; cyc(); clr();
    payout(o, h, fs, gb, tm);
    checks++;
    if (tm || o != 31 || h != 1 || gb || bus.coin_sum !== 6'd0) begin
      errors++;
      $display("FAIL ovf_refund got o%0d h%0d gap%0d t%0d want o31 h1 gap0 t0",
               o, h, gb, tm);
    end
  endtask

  task automatic test_multi_coin();
    int o, h, fs;
    bit gb, tm;
    bus.coin_ten = 1'b1; bus.coin_half = 1'b1; cyc(); clr();
    checks++;
    if ({bus.coin_reject, bus.coin_sum} !== {1'b1, 6'd20}) begin
      errors++;
      $display("FAIL multi got r%0d s%0d want r1 s20",
               bus.coin_reject, bus.coin_sum);
    end
    bus.buy = 1'b1; bus.cancel = 1'b1; bus.sel = 2'd0;
    cyc(); clr();
    checks++;
    if ({bus.vend_pulse, bus.busy, bus.coin_sum}
        !== {1'b0, 1'b1, 6'd20}) begin
      errors++;
      $display("FAIL buy_cancel got v%0d b%0d s%0d want v0 b1 s20",
               bus.vend_pulse, bus.busy, bus.coin_sum);
    end
    payout(o, h, fs, gb, tm);
    checks++;
    if (tm || o != 10 || h != 0 || gb || fs != 18) begin
      errors++;
      $display("FAIL bc_refund got o%0d h%0d fs%0d gap%0d t%0d want o10 h0 fs18",
               o, h, fs, gb, tm);
    end
  endtask

  task automatic test_idle_cmds();
    bus.buy = 1'b1; bus.sel = 2'd1; cyc(); clr();
    checks++;
    if ({bus.insufficient, bus.vend_pulse, bus.coin_sum}
        !== {1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL idle_buy got i%0d v%0d s%0d want i1 v0 s0",
               bus.insufficient, bus.vend_pulse, bus.coin_sum);
    end
    bus.cancel = 1'b1; cyc(); clr();
    cyc();
    checks++;
    if ({bus.busy, bus.change_one, bus.insufficient}
        !== 3'b000) begin
      errors++;
      $display("FAIL idle_cancel got b%0d c%0d i%0d want 0 0 0",
               bus.busy, bus.change_one, bus.insufficient);
    end
  endtask

  task automatic test_exact_vend();
    bus.coin_ten = 1'b1; cyc(); clr();
    bus.buy = 1'b1; bus.sel = 2'd3; cyc(); clr();
    checks++;
    if ({bus.vend_pulse, bus.vend_item, bus.coin_sum}
        !== {1'b1, 2'd3, 6'd0}) begin
      errors++;
      $display("FAIL exact got v%0d i%0d s%0d want v1 i3 s0",
               bus.vend_pulse, bus.vend_item, bus.coin_sum);
    end
    cyc();
    checks++;
    if ({bus.busy, bus.vend_pulse, bus.change_one} !== 3'b000) begin
      errors++;
      $display("FAIL exact_idle got b%0d v%0d c%0d want 0 0 0",
               bus.busy, bus.vend_pulse, bus.change_one);
    end
  endtask

  task automatic test_reset_mid_change();
    int seen;
    for (int i = 0; i < 3; i++) begin
      bus.coin_one = 1'b1; cyc(); clr();
    end
    bus.coin_half = 1'b1; cyc(); clr();
    bus.cancel = 1'b1; cyc(); clr();
    cyc();
    checks++;
    if ({bus.change_one, bus.coin_sum} !== {1'b1, 6'd5}) begin
      errors++;
      $display("FAIL pre_rst got c%0d s%0d want c1 s5",
               bus.change_one, bus.coin_sum);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.coin_sum, bus.change_one, bus.busy} !== 8'd0) begin
      errors++;
      $display("FAIL async_rst got s%0d c%0d b%0d want 0 0 0",
               bus.coin_sum, bus.change_one, bus.busy);
    end
    cyc();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.change_one || bus.change_half || bus.busy) seen++;
    end
    checks++;
    if (seen != 0 || bus.coin_sum !== 6'd0) begin
      errors++;
      $display("FAIL post_rst got act%0d s%0d want 0 0",
               seen, bus.coin_sum);
    end
  endtask

`ifdef VEND_TIMEOUT_REFUND_EN
  task automatic test_timeout();
    int o, h, fs, n;
    bit gb, tm;
    bus.coin_half = 1'b1; cyc(); clr();
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (bus.busy) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 50) begin
      errors++;
      $display("FAIL timeout_cyc got %0d want 50", n);
    end
    payout(o, h, fs, gb, tm);
    checks++;
    if (tm || o != 0 || h != 1 || bus.coin_sum !== 6'd0) begin
      errors++;
      $display("FAIL timeout_refund got o%0d h%0d t%0d want o0 h1 t0",
               o, h, tm);
    end
  endtask
`else
  task automatic test_hold();
    bus.coin_one = 1'b1; cyc(); clr();
    for (int i = 0; i < 120; i++) cyc();
    checks++;
    if ({bus.busy, bus.coin_sum} !== {1'b0, 6'd2}) begin
      errors++;
      $display("FAIL hold got b%0d s%0d want b0 s2",
               bus.busy, bus.coin_sum);
    end
    bus.cancel = 1'b1; cyc(); clr();
    for (int i = 0; i < 10; i++) cyc();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    clr();
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    test_reset();
    cyc();
    cyc();
    rst = 1'b0;
    test_buy_change();
    test_insufficient();
    test_overflow();
    test_multi_coin();
    test_idle_cmds();
    test_exact_vend();
    test_reset_mid_change();
`ifdef VEND_TIMEOUT_REFUND_EN
    test_timeout();
`else
    test_hold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Transaction sequencer for the vending machine. It accumulates inserted coins into a credit register, handles product select, buy and cancel, fires the vend strobe, and pays out change as timed pulses.
- Its coin_sum output drives the 7-segment digit decoder directly.
- All money is in half-yuan units: 1 LSB = 0.5 yuan, 6-bit credit, max 63 = 31.5 yuan.

Parameters:
- PRICE0, 5, price of item 0 in half-yuan units (2.5 yuan)
- PRICE1, 10, price of item 1 (5.0 yuan)
- PRICE2, 15, price of item 2 (7.5 yuan)
- PRICE3, 20, price of item 3 (10.0 yuan)
- CHANGE_GAP, 4, idle cycles between consecutive change pulses (must be >= 1)
- TIMEOUT_CYC, 1000, inactivity cycles before auto-refund (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- coin_half  input  1  one-cycle pulse: 0.5 yuan inserted
- coin_one  input  1  one-cycle pulse: 1 yuan inserted
- coin_five  input  1  one-cycle pulse: 5 yuan inserted
- coin_ten  input  1  one-cycle pulse: 10 yuan inserted
- sel  input  2  item select, sampled on the buy cycle
- buy  input  1  one-cycle purchase request
- cancel  input  1  one-cycle refund request
- coin_sum  output  6  current credit, half-yuan units (to digit decoder)
- coin_reject  output  1  one-cycle pulse: the offered coin was not accepted (returned)
- vend_pulse  output  1  one-cycle dispense strobe
- vend_item  output  2  item index, valid while vend_pulse=1
- change_one  output  1  one-cycle pulse: eject one 1-yuan coin
- change_half  output  1  one-cycle pulse: eject one 0.5-yuan coin
- insufficient  output  1  one-cycle pulse: buy refused because credit < price
- busy  output  1  high in VEND and CHANGE

Behaviour:
- Reset (async, rst=1): state=IDLE, credit=0, gap counter=0, all outputs 0. Reset mid-transaction discards credit; no change is paid.
- All outputs are registered. An event sampled at edge N is visible after edge N.
- States:
  - IDLE: credit=0.
  - COLLECT: credit>0.
  - VEND: exactly one cycle.
  - CHANGE: payout in progress.
- Coin acceptance, IDLE/COLLECT only:
  - Priority when several coin pulses arrive in one cycle: ten > five > one > half. Only the winner is considered; each losing coin pulses coin_reject (one pulse for the cycle).
  - If credit + value > 63, the coin is rejected (coin_reject=1) and credit is unchanged. No wrap-around.
  - An accepted coin moves IDLE to COLLECT.
- Coins in VEND/CHANGE are always rejected.
- buy in COLLECT:
  - If credit >= PRICE[sel]: go to VEND, vend_pulse=1, vend_item=sel, credit -= PRICE[sel].
  - Otherwise: insufficient=1, stay in COLLECT, credit unchanged.
- buy in IDLE: insufficient=1, since credit 0 is less than any price.
- cancel in COLLECT: go to CHANGE with the full credit.
- cancel in IDLE: ignored.
- buy and cancel in the same cycle: cancel wins and buy is ignored.
- A coin in the same cycle as buy/cancel is rejected. buy/cancel take precedence over coin acceptance.
- VEND to CHANGE if the remaining credit > 0, else to IDLE.
- CHANGE:
  - When the gap counter is 0: if credit >= 2, pulse change_one and credit -= 2; else if credit == 1, pulse change_half and credit = 0. Reload the gap counter to CHANGE_GAP.
  - Otherwise decrement the gap counter.
  - When credit reaches 0 and the gap counter is 0, go to IDLE.
  - The first change pulse comes in the first CHANGE cycle.
  - buy/cancel are ignored in CHANGE.
- coin_sum = credit at all times, so it counts down on the display during payout.
- Price arithmetic is 6-bit unsigned. PRICEn must be in 1..63.

Optional Feature:
- Macro: VEND_TIMEOUT_REFUND_EN.
- Defined:
  - A 16-bit inactivity counter runs in COLLECT and is cleared by any accepted coin, buy or cancel.
  - On reaching TIMEOUT_CYC the block behaves exactly as if cancel were asserted (COLLECT to CHANGE, full refund).
  - The counter is held at 0 outside COLLECT.
- Not defined: the counter is absent and credit is held indefinitely.

Test Plan:
- Reset mid-CHANGE with credit 7 -> all outputs 0 immediately (async), coin_sum=0, no further change pulses.
- coin_five, then coin_half, then buy sel=0 (price 5) -> coin_sum 10, 11, then vend_pulse with vend_item=0 and coin_sum 6, then three change_one pulses spaced CHANGE_GAP+1 cycles apart, coin_sum 4, 2, 0, then IDLE.
- coin_one, then buy sel=3 (price 20) -> insufficient pulse, coin_sum stays 2; then cancel -> one change_one, IDLE.
- Credit 60, then coin_five -> coin_reject, coin_sum stays 60. coin_one -> coin_sum 62. coin_half -> 63.
- coin_ten and coin_half in the same cycle from IDLE -> coin_sum 20 and coin_reject=1. buy and cancel in the same cycle with credit 20 -> refund path: no vend_pulse, ten change_one pulses.
- VEND_TIMEOUT_REFUND_EN defined, TIMEOUT_CYC=50: coin_half then idle -> CHANGE entered 50 cycles after the coin, one change_half pulse, IDLE.
